// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with EX/MEM and MEM/WB forwarding, immediate select and load-use hazard detection.
// Latency: an instruction in decode in cycle N drives the ALU in cycle N+1; a load-use stall adds exactly one cycle.
// Backpressure: stall_req (combinational) holds PC and IF/ID while a bubble enters EX; flush kills the entering instruction.
// Optional: define IDEX_PERF_EN to add the saturating 32-bit bubble_count output.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_use_imm,
    input  logic [3:0]         id_alu_sel,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               flush,
    input  logic [RADDR_W-1:0] exm_rd,
    input  logic               exm_reg_write,
    input  logic [XLEN-1:0]    exm_data,
    input  logic [RADDR_W-1:0] mwb_rd,
    input  logic               mwb_reg_write,
    input  logic [XLEN-1:0]    mwb_data,
    output logic               stall_req,
    output logic               ex_valid,
    output logic [XLEN-1:0]    alu_rs1,
    output logic [XLEN-1:0]    alu_rs2,
    output logic [3:0]         alu_sel,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read
`ifdef IDEX_PERF_EN
    ,
    output logic [31:0]        bubble_count
`endif
);

    // Stored EX-stage state
    logic               valid_q;
    logic [RADDR_W-1:0] rs1_addr_q;
    logic [RADDR_W-1:0] rs2_addr_q;
    logic [XLEN-1:0]    rs1_data_q;
    logic [XLEN-1:0]    rs2_data_q;
    logic [XLEN-1:0]    imm_q;
    logic               use_imm_q;
    logic [3:0]         sel_q;
    logic [RADDR_W-1:0] rd_q;
    logic               reg_write_q;
    logic               mem_read_q;

    logic               bubble;
    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;

    // Load-use hazard: the load in EX has not produced data yet, so the dependent
    // instruction must wait one cycle; a flush discards it anyway, so no stall then.
    always_comb begin
        stall_req = 1'b0;
        if (!flush && id_valid && valid_q && mem_read_q && (rd_q != '0)) begin
            if ((rd_q == id_rs1_addr) || (!id_use_imm && (rd_q == id_rs2_addr))) begin
                stall_req = 1'b1;
            end
        end
    end

    assign bubble = flush | stall_req;

    // Pipeline register: reset, then bubble on flush/stall, else capture decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            sel_q       <= 4'b0000;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (bubble) begin
            // Payload fields are held; only the qualifiers are cleared.
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= id_valid;
            rs1_addr_q  <= id_rs1_addr;
            rs2_addr_q  <= id_rs2_addr;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            use_imm_q   <= id_use_imm;
            sel_q       <= id_alu_sel;
            rd_q        <= id_rd;
            reg_write_q <= id_reg_write & id_valid;
            mem_read_q  <= id_mem_read & id_valid;
        end
    end

    // Forwarding per source: EX/MEM beats MEM/WB, x0 is never forwarded.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs1_addr_q)) begin
            fwd_rs1 = exm_data;
        end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs1_addr_q)) begin
            fwd_rs1 = mwb_data;
        end

        fwd_rs2 = rs2_data_q;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs2_addr_q)) begin
            fwd_rs2 = exm_data;
        end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs2_addr_q)) begin
            fwd_rs2 = mwb_data;
        end
    end

    assign alu_rs1      = fwd_rs1;
    assign alu_rs2      = use_imm_q ? imm_q : fwd_rs2;
    assign alu_sel      = sel_q;
    assign ex_valid     = valid_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = valid_q & reg_write_q;
    assign ex_mem_read  = valid_q & mem_read_q;

`ifdef IDEX_PERF_EN
    // Count bubbles that displaced a real decode instruction, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (bubble && id_valid && (bubble_count != 32'hFFFF_FFFF)) begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that directly feeds the ALU operand and select inputs (rs1, rs2, sel).
- Captures decoded operands each cycle and resolves EX/MEM and MEM/WB forwarding.
- Selects register or immediate for the second operand.
- Detects load-use hazards and inserts a one-cycle bubble, with a stall request back to fetch/decode.

Parameters:
- XLEN, 32, operand/result width.
- RADDR_W, 5, register address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  decode slot holds a real instruction.
- id_rs1_addr  input  RADDR_W  source register 1 index.
- id_rs2_addr  input  RADDR_W  source register 2 index.
- id_rs1_data  input  XLEN  register file read 1.
- id_rs2_data  input  XLEN  register file read 2.
- id_imm  input  XLEN  sign-extended immediate.
- id_use_imm  input  1  operand 2 is the immediate.
- id_alu_sel  input  4  ALU operation: ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100, OR 0110, AND 0111, SLL 1010, SRL 1101, SRA 1110.
- id_rd  input  RADDR_W  destination register.
- id_reg_write  input  1  instruction writes rd.
- id_mem_read  input  1  instruction is a load.
- flush  input  1  branch/jump redirect; kill the instruction entering EX.
- exm_rd  input  RADDR_W  EX/MEM destination.
- exm_reg_write  input  1  EX/MEM writes.
- exm_data  input  XLEN  EX/MEM ALU result.
- mwb_rd  input  RADDR_W  MEM/WB destination.
- mwb_reg_write  input  1  MEM/WB writes.
- mwb_data  input  XLEN  MEM/WB writeback value.
- stall_req  output  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  output  1  EX slot valid.
- alu_rs1  output  XLEN  forwarded operand 1 to ALU.
- alu_rs2  output  XLEN  forwarded operand 2, or immediate.
- alu_sel  output  4  registered select to ALU.
- ex_rd  output  RADDR_W  registered destination.
- ex_reg_write  output  1  qualified by ex_valid.
- ex_mem_read  output  1  qualified by ex_valid.

Behaviour:
- Reset (rst=1 at an edge): all registered state is zero. ex_valid=0, alu_sel=0000, ex_rd=0, ex_reg_write=0, ex_mem_read=0, and stored operands/immediate/use_imm/addresses are zero. As a result, alu_rs1=alu_rs2=0 (no forwarding from x0). rst overrides flush and stall.
- Load-use hazard, combinational:
  - stall_req = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1_addr) | (!id_use_imm & ex_rd == id_rs2_addr)).
  - stall_req is forced to 0 while flush=1.
- Register update each edge, in priority order:
  - rst: reset values.
  - flush: bubble (ex_valid=0, ex_reg_write=0, ex_mem_read=0; other fields don't-care but held).
  - stall_req: bubble.
  - Otherwise: capture all id_* fields, with ex_valid=id_valid. id_reg_write and id_mem_read are gated by id_valid.
- Latency: an instruction presented at decode in cycle N drives the ALU in cycle N+1. A stall adds exactly one cycle.
- Forwarding, combinational at EX, applied per source using the stored rs addresses:
  - EX/MEM has priority: use exm_data if exm_reg_write & exm_rd != 0 & exm_rd == src.
  - Else MEM/WB: use mwb_data if mwb_reg_write & mwb_rd != 0 & mwb_rd == src.
  - Else use the stored register file data.
  - Address 0 is never forwarded.
- Operand 2: alu_rs2 = stored imm when use_imm=1; forwarding for rs2 is ignored in that case.
- alu_sel is passed unmodified; this block does no arithmetic.
- Bubble: alu_sel=0000 is not required. Downstream qualifies with ex_valid, ex_reg_write and ex_mem_read.
- Reset mid-stall: the next cycle is a bubble and stall_req drops.

Optional Feature:
- IDEX_PERF_EN defined: adds output bubble_count (32-bit).
  - Increments by 1 on each edge where a bubble is inserted due to stall_req or flush with id_valid=1.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, ex_reg_write=0, alu_rs1=alu_rs2=0, stall_req=0.
- Plain capture: id rs1_data=0x0000000C, rs2_data=0x00000003, alu_sel=0001, rd=5, id_valid=1, no forwarding -> next cycle alu_rs1=0xC, alu_rs2=0x3, alu_sel=0001, ex_rd=5, ex_valid=1.
- Forward priority: EX rs1=x7 with exm_rd=7/exm_data=0xAAAA0000 and mwb_rd=7/mwb_data=0x5555 -> alu_rs1=0xAAAA0000. Then exm_reg_write=0 -> alu_rs1=0x5555. Then rd=0 with writes=1 -> stored data.
- Immediate select: use_imm=1, imm=0xFFFFFFFC, exm_rd equal to rs2_addr -> alu_rs2=0xFFFFFFFC.
- Load-use: EX holds load to x3 (valid), decode rs2=x3 with use_imm=0 -> stall_req=1 for one cycle, next ex_valid=0. The following cycle captures the held instruction (stall_req=0).
- Flush over stall: hazard present plus flush=1 -> stall_req=0, next ex_valid=0. With IDEX_PERF_EN, bubble_count increments by 1.
